fetch_pc_gen: RTL

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen_pkg.sv | 29 ++
 rtl/fetch_buf.sv | 69 ++++++
 rtl/fetch_pc_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage definitions: defaults, widths, FSM encoding and buffer entry layout.
package fetch_pc_gen_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT   = 64'h0000_0000_8000_0000;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;
  localparam int unsigned INST_W             = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // One fetched instruction as handed to decode (161 bits).
  typedef struct packed {
    logic [63:0]       pc;
    logic [INST_W-1:0] inst;
    logic              pred_taken;
    logic [63:0]       pred_next_pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Sequential successor; wraps modulo 2^64.
  function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched instructions; flush empties it and wins over push/pop.
module fetch_buf #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 161
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [Width-1:0]           head_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush dominates.
  always_comb begin
    do_push  = push_i & ~full_o & ~flush_i;
    do_pop   = pop_i & ~empty_o & ~flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one outstanding imem request, predictor-steered next PC,
// redirect handling and a small decode-side instruction buffer.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_redirect_valid,
  input  logic [63:0]       io_redirect_pc,
  output logic [63:0]       io_pc,
  input  logic              io_pre_valid,
  input  logic [63:0]       io_pre_next_pc,
  output logic              io_imem_req_valid,
  input  logic              io_imem_req_ready,
  output logic [63:0]       io_imem_req_addr,
  input  logic              io_imem_resp_valid,
  input  logic [INST_W-1:0] io_imem_resp_inst,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [63:0]       io_out_pc,
  output logic [INST_W-1:0] io_out_inst,
  output logic              io_out_pred_taken,
  output logic [63:0]       io_out_pred_next_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  infl_pc_q, infl_pc_d;
  logic         infl_taken_q, infl_taken_d;
  logic [63:0]  infl_next_q, infl_next_d;

  fetch_entry_t buf_head, buf_push_data;
  logic [CntW-1:0] buf_count;
  logic         buf_full, buf_empty, buf_push, buf_pop;
  logic         req_fire;

  assign io_pc            = pc_q;
  assign io_imem_req_addr = pc_q;

  // Decode side reads straight from the buffer head; no bypass.
  assign io_out_valid        = ~buf_empty & ~reset;
  assign io_out_pc           = buf_head.pc;
  assign io_out_inst         = buf_head.inst;
  assign io_out_pred_taken   = buf_head.pred_taken;
  assign io_out_pred_next_pc = buf_head.pred_next_pc;

  assign buf_push_data = '{pc: infl_pc_q, inst: io_imem_resp_inst,
                           pred_taken: infl_taken_q, pred_next_pc: infl_next_q};

  // Request gating, FSM next state and PC selection; redirect has top priority.
  always_comb begin
    io_imem_req_valid = (state_q == S_REQ) && (32'(buf_count) < FIFO_DEPTH) &&
                        !io_redirect_valid && !reset;
    req_fire     = io_imem_req_valid & io_imem_req_ready;
    state_d      = state_q;
    pc_d         = pc_q;
    infl_pc_d    = infl_pc_q;
    infl_taken_d = infl_taken_q;
    infl_next_d  = infl_next_q;
    buf_push     = 1'b0;
    buf_pop      = io_out_valid & io_out_ready & ~io_redirect_valid;
    if (io_redirect_valid) begin
      pc_d = io_redirect_pc;
      unique case (state_q)
        S_REQ:          state_d = S_REQ;
        S_WAIT, S_DROP: state_d = io_imem_resp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            infl_pc_d    = pc_q;
            infl_taken_d = io_pre_valid;
            infl_next_d  = io_pre_next_pc;
            pc_d         = io_pre_valid ? io_pre_next_pc : next_seq_pc(pc_q);
            state_d      = S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_imem_resp_valid) begin
            buf_push = ~buf_full;
            state_d  = S_REQ;
          end
        end
        S_DROP: begin
          if (io_imem_resp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // PC, FSM and in-flight registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      state_q      <= S_REQ;
      infl_pc_q    <= '0;
      infl_taken_q <= 1'b0;
      infl_next_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      infl_pc_q    <= infl_pc_d;
      infl_taken_q <= infl_taken_d;
      infl_next_q  <= infl_next_d;
    end
  end

  fetch_buf #(
    .Depth (FIFO_DEPTH),
    .Width (ENTRY_W)
  ) u_fetch_buf (
    .clock       (clock),
    .reset       (reset),
    .push_i      (buf_push),
    .push_data_i (buf_push_data),
    .pop_i       (buf_pop),
    .flush_i     (io_redirect_valid),
    .head_o      (buf_head),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

endmodule
